// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO for the filter datapath.
//   Any depth >= 2 is supported, and the pointers wrap at DEPTH-1.
//   Writes are ignored while full and reads are ignored while empty.
//   The FIFO exports its fill count and almost-full/almost-empty flags.
//   READ_MODE selects the read style:
//     0 = first-word-fall-through (FWFT).
//     1 = registered, with a one-cycle read latency.
//   Optional sticky overflow/underflow flags are enabled by defining
//   SYNC_FIFO_FLAGS_ERR_EN. The port list is the same either way.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   din, wr_en          write data and write request
//   rd_en               read request
//   dout, dout_vld      read data and its valid flag
//   full, empty         count == DEPTH, count == 0
//   almost_full/_empty  count >= AF_THRESH, count <= AE_THRESH
//   count               current fill level
//   err_clr             synchronous clear of the sticky error flags
//   overflow/underflow  sticky flags: write while full, read while empty
module sync_fifo_flags #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter int unsigned READ_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             din,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         dout_vld,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         err_clr,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Elaboration-time parameter checks
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_flags: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_THRESH out of range 0..DEPTH-1");
    end
    if (READ_MODE > 1) begin : g_bad_mode
        $error("sync_fifo_flags: READ_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Advance a pointer, wrapping at DEPTH-1 so non-power-of-2 depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Flags are decoded directly from the registered count
    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // Pointers and fill level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array: not reset, so it can map onto inferred RAM
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    if (READ_MODE == 0) begin : g_fwft
        // Show the head entry while not empty, and drive zero otherwise,
        // so dout is zero after reset.
        assign dout     = empty ? '0 : mem[rd_ptr];
        assign dout_vld = !empty;
    end else begin : g_reg
        // Registered read: the data appears one cycle after the accepted read
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout     <= '0;
                dout_vld <= 1'b0;
            end else begin
                dout_vld <= rd_acc;
                if (rd_acc) dout <= mem[rd_ptr];
            end
        end
    end

`ifdef SYNC_FIFO_FLAGS_ERR_EN
    // Sticky error flags: a set takes priority over a clear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            else if (err_clr)   overflow  <= 1'b0;
            if (rd_en && empty) underflow <= 1'b1;
            else if (err_clr)   underflow <= 1'b0;
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags.
// dut0 is an FWFT instance and dut1 is a registered-read instance; both have DEPTH=5.
// The stimulus tasks push the expected read data into the exp0/exp1 queues.
// A separate negedge monitor pops those queues and compares whenever a DUT presents data.
module tb_sync_fifo_flags;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 5;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst0_n, rst1_n;
    logic [W-1:0]  din0, din1;
    logic          wr0, rd0, wr1, rd1, err_clr;

    logic [W-1:0]  dout0, dout1;
    logic          vld0, vld1, full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1, ov0, ov1, un0, un1;
    logic [CW-1:0] cnt0, cnt1;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  m0[$], m1[$], exp0[$], exp1[$];
    logic          e_ov, e_un;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(3), .AE_THRESH(2), .READ_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .din(din0), .wr_en(wr0), .rd_en(rd0),
        .dout(dout0), .dout_vld(vld0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .err_clr(err_clr), .overflow(ov0), .underflow(un0));

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_THRESH(3), .AE_THRESH(2), .READ_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .din(din1), .wr_en(wr1), .rd_en(rd1),
        .dout(dout1), .dout_vld(vld1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .err_clr(err_clr), .overflow(ov1), .underflow(un1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare each presented output word against the queue
    always @(negedge clk) begin
        if (rst0_n && rd0 && vld0) begin
            if (exp0.size() == 0) check("fwft_unexpected_read", 32'(dout0), 32'hdead);
            else check("fwft_dout", 32'(dout0), 32'(exp0.pop_front()));
        end
        if (rst1_n && vld1) begin
            if (exp1.size() == 0) check("reg_unexpected_vld", 32'(dout1), 32'hdead);
            else check("reg_dout", 32'(dout1), 32'(exp1.pop_front()));
        end
    end

    // One FWFT cycle; models acceptance from the pre-edge fill level
    task automatic step0(input logic w, input logic r, input logic [W-1:0] d, input logic clr);
        logic wa, ra;
        wa = w && (m0.size() < D);
        ra = r && (m0.size() > 0);
        if (w && m0.size() == D) e_ov = 1'b1;
        else if (clr)            e_ov = 1'b0;
        if (r && m0.size() == 0) e_un = 1'b1;
        else if (clr)            e_un = 1'b0;
        wr0 = w; rd0 = r; din0 = d; err_clr = clr;
        if (ra) exp0.push_back(m0.pop_front());
        if (wa) m0.push_back(d);
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0; err_clr = 1'b0;
    endtask

    task automatic flags0(input string tag);
        int n;
        n = m0.size();
        check({tag, "_count"}, 32'(cnt0), 32'(n));
        check({tag, "_full"},  32'(full0), 32'(n == D));
        check({tag, "_empty"}, 32'(empty0), 32'(n == 0));
        check({tag, "_af"},    32'(af0), 32'(n >= 3));
        check({tag, "_ae"},    32'(ae0), 32'(n <= 2));
    endtask

    task automatic step1(input logic w, input logic r, input logic [W-1:0] d);
        logic wa, ra;
        wa = w && (m1.size() < D);
        ra = r && (m1.size() > 0);
        wr1 = w; rd1 = r; din1 = d;
        if (ra) exp1.push_back(m1.pop_front());
        if (wa) m1.push_back(d);
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic check_err(input string tag);
`ifdef SYNC_FIFO_FLAGS_ERR_EN
        check({tag, "_overflow"},  32'(ov0), 32'(e_ov));
        check({tag, "_underflow"}, 32'(un0), 32'(e_un));
`else
        check({tag, "_overflow"},  32'(ov0), 32'(1'b0));
        check({tag, "_underflow"}, 32'(un0), 32'(1'b0));
`endif
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        din0 = '0; din1 = '0; wr0 = 0; rd0 = 0; wr1 = 0; rd1 = 0; err_clr = 0;
        e_ov = 1'b0; e_un = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst0_n = 1'b1; rst1_n = 1'b1;

        // Reset and idle state
        step0(0, 0, 8'h00, 0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_full",  32'(full0),  32'd0);
        check("rst_count", 32'(cnt0),   32'd0);
        check("rst_ae",    32'(ae0),    32'd1);
        check("rst_vld",   32'(vld0),   32'd0);
        check("rst_dout",  32'(dout0),  32'd0);
        check("rst_vld1",  32'(vld1),   32'd0);
        check_err("rst");

        // Fill to full, then attempt a 6th write
        for (int i = 0; i < 5; i++) begin
            step0(1, 0, W'(8'h11 + i), 0);
            flags0("fill");
        end
        check("full_after_5", 32'(full0), 32'd1);
        step0(1, 0, 8'h99, 0);
        check("count_after_6th", 32'(cnt0), 32'd5);
        check_err("ovf");

        // Drain in FWFT, then one extra read while empty
        for (int i = 0; i < 5; i++) begin
            step0(0, 1, 8'h00, 0);
            flags0("drain");
        end
        check("empty_after_5rd", 32'(empty0), 32'd1);
        step0(0, 1, 8'h00, 0);
        check("count_extra_rd", 32'(cnt0), 32'd0);
        check_err("unf");
        step0(0, 0, 8'h00, 1);
        check_err("clr");

        // Pointer wrap: prime one entry, then 12 simultaneous write+read cycles
        step0(1, 0, 8'h20, 0);
        for (int i = 0; i < 12; i++) begin
            step0(1, 1, W'(8'h21 + i), 0);
            check("wrap_count", 32'(cnt0), 32'd1);
        end
        step0(0, 1, 8'h00, 0);
        flags0("wrap_end");

        // Simultaneous write and read while full: the read wins and din is dropped
        for (int i = 0; i < 5; i++) step0(1, 0, W'(8'h30 + i), 0);
        step0(1, 1, 8'hEE, 0);
        check("full_rw_count", 32'(cnt0), 32'd4);
        for (int i = 0; i < 4; i++) step0(0, 1, 8'h00, 0);
        check("full_rw_drained", 32'(empty0), 32'd1);

        // Simultaneous write and read while empty: the write wins and no data is output
        step0(1, 1, 8'h40, 0);
        check("empty_rw_count", 32'(cnt0), 32'd1);
        step0(0, 1, 8'h00, 0);
        flags0("empty_rw_end");
        step0(0, 0, 8'h00, 1);

        // Registered read mode: one-cycle latency, dout holds afterwards
        step1(1, 0, 8'hA5);
        step1(0, 1, 8'h00);
        check("reg_vld_lat1", 32'(vld1),  32'd1);
        check("reg_dout_lat1", 32'(dout1), 32'hA5);
        step1(0, 0, 8'h00);
        check("reg_vld_drop", 32'(vld1),  32'd0);
        check("reg_dout_hold", 32'(dout1), 32'hA5);

        // Asynchronous reset in the middle of a burst
        step1(1, 0, 8'h01);
        step1(1, 0, 8'h02);
        wr1 = 1'b1; din1 = 8'h03;
        #2 rst1_n = 1'b0;
        #1;
        check("arst_count", 32'(cnt1),   32'd0);
        check("arst_empty", 32'(empty1), 32'd1);
        check("arst_vld",   32'(vld1),   32'd0);
        check("arst_dout",  32'(dout1),  32'd0);
        m1.delete();
        wr1 = 1'b0;
        @(posedge clk); #1 rst1_n = 1'b1;
        step1(0, 0, 8'h00);
        check("arst_hold_count", 32'(cnt1), 32'd0);

        @(posedge clk); #1;
        check("sb_fwft_drained", 32'(exp0.size()), 32'd0);
        check("sb_reg_drained",  32'(exp1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
